// File: rtl/tetris_input_ctrl.sv
// -----------------------------------------------------------------------------
// tetris_input_ctrl
//   Turns five raw push-buttons into single-cycle move commands for the tetris
//   game logic. Each button passes through a 2-flop synchroniser and a counter
//   debouncer. Left, right and soft-drop then feed an auto-repeat FSM with a
//   delayed auto-shift (DAS) followed by a steady auto-repeat (ARR) rate.
//   Rotate and hard-drop fire once per debounced press.
//
// Parameters
//   DEB_CYCLES  consecutive stable cycles needed to change a debounced level
//   DAS_DELAY   cycles from the first pulse to the first repeat pulse
//   ARR_PERIOD  cycles between later repeat pulses
//   CNT_W       counter width; must hold max(DEB_CYCLES, DAS_DELAY, ARR_PERIOD)
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   E                             enable (game screen active)
//   btnL/btnR/btnD/btnU/btnC      raw asynchronous buttons
//   mvL/mvR/mvD/mvRot/mvDrop      one-cycle move pulses
// -----------------------------------------------------------------------------
module tetris_input_ctrl #(
    parameter int DEB_CYCLES = 1_000_000,
    parameter int DAS_DELAY  = 20_000_000,
    parameter int ARR_PERIOD = 5_000_000,
    parameter int CNT_W      = 25
) (
    input  logic clk,
    input  logic rst,
    input  logic E,
    input  logic btnL,
    input  logic btnR,
    input  logic btnD,
    input  logic btnU,
    input  logic btnC,
    output logic mvL,
    output logic mvR,
    output logic mvD,
    output logic mvRot,
    output logic mvDrop
);

    localparam int NBTN  = 5;
    localparam int NREP  = 3;   // buttons 0..NREP-1 auto-repeat
    localparam int IDX_L = 0;
    localparam int IDX_R = 1;
    localparam int IDX_D = 2;
    localparam int IDX_U = 3;
    localparam int IDX_C = 4;

    // Counters are compared against "last" values so that the terminal event
    // lands on the correct cycle without an extra compare stage.
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] DAS_LOAD = CNT_W'(DAS_DELAY - 1);
    localparam logic [CNT_W-1:0] ARR_LOAD = CNT_W'(ARR_PERIOD - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DELAY,
        ST_REPEAT
    } rep_state_t;

    logic [NBTN-1:0] raw_btn;
    logic [NBTN-1:0] rise;          // debounced rising edge, one cycle
    logic [NREP-1:0] level;         // debounced level of repeating buttons
    logic [NREP-1:0] rep_pulse;
    logic            lr_conflict;
    logic            rot_pulse_reg;
    logic            drop_pulse_reg;

    assign raw_btn = {btnC, btnU, btnD, btnR, btnL};

    genvar gi;

    // -------------------------------------------------------------------------
    // Synchroniser + debouncer per button
    // -------------------------------------------------------------------------
    generate
        for (gi = 0; gi < NBTN; gi++) begin : g_btn
            logic             sync1_reg;
            logic             sync2_reg;
            logic             level_reg;
            logic             level_d_reg;
            logic [CNT_W-1:0] deb_cnt_reg;

            always_ff @(posedge clk) begin
                if (rst) begin
                    sync1_reg   <= 1'b0;
                    sync2_reg   <= 1'b0;
                    level_reg   <= 1'b0;
                    level_d_reg <= 1'b0;
                    deb_cnt_reg <= '0;
                end else begin
                    sync1_reg   <= raw_btn[gi];
                    sync2_reg   <= sync1_reg;
                    level_d_reg <= level_reg;
                    if (sync2_reg == level_reg) begin
                        deb_cnt_reg <= '0;
                    end else if (deb_cnt_reg >= DEB_LAST) begin
                        // DEB_CYCLES-th consecutive disagreeing sample: flip.
                        // The >= test also keeps the count from ever wrapping.
                        level_reg   <= sync2_reg;
                        deb_cnt_reg <= '0;
                    end else begin
                        deb_cnt_reg <= deb_cnt_reg + 1'b1;
                    end
                end
            end

            assign rise[gi] = level_reg & ~level_d_reg;

            if (gi < NREP) begin : g_lvl
                assign level[gi] = level_reg;
            end
        end
    endgenerate

    // Left and right together cancel each other; because the FSMs only leave
    // IDLE on a rising edge, a button still held after the conflict ends stays
    // silent until it is released and pressed again.
    assign lr_conflict = level[IDX_L] & level[IDX_R];

    // -------------------------------------------------------------------------
    // DAS / ARR auto-repeat FSMs for left, right, soft-drop
    // -------------------------------------------------------------------------
    generate
        for (gi = 0; gi < NREP; gi++) begin : g_rep
            localparam bit LR_PAIR = (gi != IDX_D);

            rep_state_t       state_reg;
            logic [CNT_W-1:0] rep_cnt_reg;
            logic             pulse_reg;
            logic             hold_ok;

            assign hold_ok = E && level[gi] && !(LR_PAIR && lr_conflict);

            always_ff @(posedge clk) begin
                if (rst) begin
                    state_reg   <= ST_IDLE;
                    rep_cnt_reg <= '0;
                    pulse_reg   <= 1'b0;
                end else begin
                    pulse_reg <= 1'b0;
                    if (!hold_ok) begin
                        state_reg   <= ST_IDLE;
                        rep_cnt_reg <= '0;
                    end else begin
                        case (state_reg)
                            ST_IDLE: begin
                                if (rise[gi]) begin
                                    pulse_reg   <= 1'b1;
                                    rep_cnt_reg <= DAS_LOAD;
                                    state_reg   <= ST_DELAY;
                                end
                            end
                            ST_DELAY: begin
                                if (rep_cnt_reg == '0) begin
                                    pulse_reg   <= 1'b1;
                                    rep_cnt_reg <= ARR_LOAD;
                                    state_reg   <= ST_REPEAT;
                                end else begin
                                    rep_cnt_reg <= rep_cnt_reg - 1'b1;
                                end
                            end
                            ST_REPEAT: begin
                                if (rep_cnt_reg == '0) begin
                                    pulse_reg   <= 1'b1;
                                    rep_cnt_reg <= ARR_LOAD;
                                end else begin
                                    rep_cnt_reg <= rep_cnt_reg - 1'b1;
                                end
                            end
                            default: begin
                                state_reg   <= ST_IDLE;
                                rep_cnt_reg <= '0;
                            end
                        endcase
                    end
                end
            end

            assign rep_pulse[gi] = pulse_reg;
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Edge-only rotate and hard drop
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            rot_pulse_reg  <= 1'b0;
            drop_pulse_reg <= 1'b0;
        end else begin
            rot_pulse_reg  <= E & rise[IDX_U];
            drop_pulse_reg <= E & rise[IDX_C];
        end
    end

    // Hard drop wins: the other commands are masked in its cycle, but their
    // FSMs keep running so repeat timing is unaffected.
    assign mvDrop = drop_pulse_reg;
    assign mvRot  = rot_pulse_reg     & ~drop_pulse_reg;
    assign mvL    = rep_pulse[IDX_L]  & ~drop_pulse_reg;
    assign mvR    = rep_pulse[IDX_R]  & ~drop_pulse_reg;
    assign mvD    = rep_pulse[IDX_D]  & ~drop_pulse_reg;

endmodule
